// File: rtl/jk_reg_bank.sv
// WIDTH-bit register whose bits act as independent JK flip-flops, with added
// LOAD, TOGGLE and up/down modulo COUNT modes, clock enable, terminal count and change strobe.
module jk_reg_bank #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter longint unsigned   MOD       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             changed
);

    typedef enum logic [1:0] {
        MODE_JK     = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    // A zero modulus wraps at 2^WIDTH, so the last count value is all ones.
    localparam bit               MODULAR = (MOD != 0);
    localparam logic [WIDTH-1:0] LAST    = MODULAR ? WIDTH'(MOD - 1) : {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] count_next;
    logic             out_of_range;

    // Characteristic equation of a JK flip-flop, one cell per bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bit
            assign jk_next[gi] = (j[gi] & ~q_q[gi]) | (~k[gi] & q_q[gi]);
        end
    endgenerate

    // A value loaded in another mode may sit above the modulus; COUNT recovers to 0.
    assign out_of_range = MODULAR && (64'(q_q) >= MOD);

    always_comb begin
        count_next = q_q;
        if (out_of_range) begin
            count_next = '0;
        end else if (up) begin
            count_next = (q_q == LAST) ? '0 : q_q + WIDTH'(1);
        end else begin
            count_next = (q_q == '0) ? LAST : q_q - WIDTH'(1);
        end
    end

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_e'(mode))
                MODE_JK:     q_d = jk_next;
                MODE_LOAD:   q_d = j;
                MODE_TOGGLE: q_d = q_q ^ j;
                MODE_COUNT:  q_d = count_next;
                default:     q_d = q_q;
            endcase
        end
        changed_d = en && (q_d != q_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign changed = changed_q;
    assign tc      = (mode_e'(mode) == MODE_COUNT) && (up ? (q_q == LAST) : (q_q == '0));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Bench for jk_reg_bank: three instances (4-bit free wrap, 4-bit mod 10, 1-bit)
// checked against an integer-arithmetic model of the mode rules.
module tb_jk_reg_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_en = 0, b_en = 0, c_en = 0;
    logic [1:0] a_mode = 0, b_mode = 0, c_mode = 0;
    logic [3:0] a_j = 0, a_k = 0, b_j = 0, b_k = 0;
    logic [0:0] c_j = 0, c_k = 0;
    logic       a_up = 0, b_up = 0, c_up = 0;
    logic [3:0] a_q, a_qn, b_q, b_qn;
    logic [0:0] c_q, c_qn;
    logic       a_tc, b_tc, c_tc, a_changed, b_changed, c_changed;

    int total = 0;
    int bad   = 0;
    int ma_q, mb_q, mc_q;
    bit ma_changed, mb_changed, mc_changed;

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'd0), .MOD(0)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .j(a_j), .k(a_k), .up(a_up),
        .q(a_q), .qn(a_qn), .tc(a_tc), .changed(a_changed));
    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'd3), .MOD(10)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .j(b_j), .k(b_k), .up(b_up),
        .q(b_q), .qn(b_qn), .tc(b_tc), .changed(b_changed));
    jk_reg_bank #(.WIDTH(1), .RESET_VAL(1'b0), .MOD(0)) u_c (
        .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .j(c_j), .k(c_k), .up(c_up),
        .q(c_q), .qn(c_qn), .tc(c_tc), .changed(c_changed));

    // Reference next-state from the mode rules, using plain integer arithmetic.
    function automatic int model_next(int q, int width, int mod, bit en, int mode,
                                      int j, int k, bit up);
        int m;
        int r;
        m = (mod == 0) ? (1 << width) : mod;
        if (!en) return q;
        case (mode)
            0: begin
                r = 0;
                for (int i = 0; i < width; i++) begin
                    int jb, kb, qb;
                    jb = (j >> i) & 1; kb = (k >> i) & 1; qb = (q >> i) & 1;
                    if (jb == 0 && kb == 0) r = r | (qb << i);
                    else if (jb == 1 && kb == 0) r = r | (1 << i);
                    else if (jb == 1 && kb == 1) r = r | ((1 - qb) << i);
                end
                return r;
            end
            1: return j;
            2: return q ^ j;
            default: begin
                if (q >= m) return 0;
                return up ? (q + 1) % m : (q + m - 1) % m;
            end
        endcase
    endfunction

    function automatic bit model_tc(int q, int width, int mod, int mode, bit up);
        int m;
        m = (mod == 0) ? (1 << width) : mod;
        return (mode == 3) && ((up && q == m - 1) || (!up && q == 0));
    endfunction

    task automatic reset_model();
        ma_q = 0; mb_q = 3; mc_q = 0;
        ma_changed = 0; mb_changed = 0; mc_changed = 0;
    endtask

    task automatic tick();
        int na, nb, nc;
        na = model_next(ma_q, 4, 0,  a_en, a_mode, a_j, a_k, a_up);
        nb = model_next(mb_q, 4, 10, b_en, b_mode, b_j, b_k, b_up);
        nc = model_next(mc_q, 1, 0,  c_en, c_mode, c_j, c_k, c_up);
        @(posedge clk);
        #1;
        ma_changed = a_en && (na != ma_q); ma_q = na;
        mb_changed = b_en && (nb != mb_q); mb_q = nb;
        mc_changed = c_en && (nc != mc_q); mc_q = nc;
        $display("t=%0t a:m%0d q=%h ch=%b | b:m%0d q=%h ch=%b | c:m%0d q=%b",
                 $time, a_mode, a_q, a_changed, b_mode, b_q, b_changed, c_mode, c_q);
    endtask

    task automatic test_reset();
        rst = 1'b1; a_mode = 2'b11; a_up = 1'b0;
        reset_model();
        #12;
        total++; if (a_q !== 4'h0 || a_qn !== 4'hF) begin bad++; $display("FAIL reset_a got q=%h qn=%h exp q=0 qn=f", a_q, a_qn); end
        total++; if (b_q !== 4'h3 || b_changed !== 1'b0) begin bad++; $display("FAIL reset_b got q=%h ch=%b exp q=3 ch=0", b_q, b_changed); end
        total++; if (a_tc !== 1'b1) begin bad++; $display("FAIL reset_tc got=%b exp=1", a_tc); end
        total++; if (c_q !== 1'b0 || c_changed !== 1'b0) begin bad++; $display("FAIL reset_c got q=%b ch=%b exp 0 0", c_q, c_changed); end
        rst = 1'b0;
    endtask

    task automatic test_jk();
        a_en = 1; a_mode = 2'b00; a_j = 4'b1100; a_k = 4'b1010;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++; if (a_q !== ma_q[3:0] || a_changed !== 1'b1) begin bad++; $display("FAIL jk_step%0d got q=%h ch=%b exp q=%h ch=1", n, a_q, a_changed, ma_q[3:0]); end
        end
        a_j = 4'b0000; a_k = 4'b0000;
        tick();
        total++; if (a_q !== 4'b0100 || a_changed !== 1'b0) begin bad++; $display("FAIL jk_hold got q=%b ch=%b exp q=0100 ch=0", a_q, a_changed); end
    endtask

    task automatic test_load_toggle();
        a_en = 1; a_mode = 2'b01; a_j = 4'hA;
        tick();
        total++; if (a_q !== 4'hA) begin bad++; $display("FAIL load got=%h exp=a", a_q); end
        a_mode = 2'b10; a_j = 4'hF;
        tick();
        total++; if (a_q !== 4'h5 || a_qn !== 4'hA) begin bad++; $display("FAIL toggle got q=%h qn=%h exp 5 a", a_q, a_qn); end
        a_en = 0;
        tick();
        total++; if (a_q !== 4'h5 || a_changed !== 1'b0) begin bad++; $display("FAIL en_hold got q=%h ch=%b exp 5 0", a_q, a_changed); end
        total++; if (a_tc !== 1'b0) begin bad++; $display("FAIL tc_noncount got=%b exp=0", a_tc); end
    endtask

    task automatic test_count_free();
        a_en = 1; a_mode = 2'b01; a_j = 4'hE;
        tick();
        a_mode = 2'b11; a_up = 1;
        tick();
        total++; if (a_q !== 4'hF || a_tc !== 1'b1) begin bad++; $display("FAIL free_up_f got q=%h tc=%b exp f 1", a_q, a_tc); end
        tick();
        total++; if (a_q !== 4'h0 || a_tc !== 1'b0) begin bad++; $display("FAIL free_wrap got q=%h tc=%b exp 0 0", a_q, a_tc); end
        a_up = 0;
        #1;
        total++; if (a_tc !== 1'b1) begin bad++; $display("FAIL free_dn_tc got=%b exp=1", a_tc); end
        tick();
        total++; if (a_q !== 4'hF) begin bad++; $display("FAIL free_dn_wrap got=%h exp=f", a_q); end
    endtask

    task automatic test_count_mod();
        b_en = 1; b_mode = 2'b01; b_j = 4'd8;
        tick();
        b_mode = 2'b11; b_up = 1;
        tick();
        total++; if (b_q !== 4'd9 || b_tc !== 1'b1) begin bad++; $display("FAIL mod_up9 got q=%0d tc=%b exp 9 1", b_q, b_tc); end
        tick();
        total++; if (b_q !== 4'd0) begin bad++; $display("FAIL mod_wrap got=%0d exp=0", b_q); end
        b_up = 0;
        tick();
        total++; if (b_q !== 4'd9 || b_tc !== 1'b0) begin bad++; $display("FAIL mod_dn got q=%0d tc=%b exp 9 0", b_q, b_tc); end
        b_mode = 2'b01; b_j = 4'd12;
        tick();
        b_mode = 2'b11;
        tick();
        total++; if (b_q !== 4'd0 || b_changed !== 1'b1) begin bad++; $display("FAIL mod_oor got q=%0d ch=%b exp 0 1", b_q, b_changed); end
    endtask

    task automatic test_async_reset();
        b_en = 1; b_mode = 2'b01; b_j = 4'd7;
        tick();
        b_mode = 2'b11; b_up = 1;
        #2 rst = 1'b1;
        reset_model();
        #1;
        total++; if (b_q !== 4'd3 || b_changed !== 1'b0) begin bad++; $display("FAIL async_rst got q=%0d ch=%b exp 3 0", b_q, b_changed); end
        #2 rst = 1'b0;
        tick();
        total++; if (b_q !== 4'd4 || b_changed !== 1'b1) begin bad++; $display("FAIL post_rst got q=%0d ch=%b exp 4 1", b_q, b_changed); end
    endtask

    task automatic test_width1();
        logic [1:0] seq [5];
        logic       expq [5];
        seq  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        expq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        c_en = 1; c_mode = 2'b00;
        for (int n = 0; n < 5; n++) begin
            c_j = seq[n][1]; c_k = seq[n][0];
            tick();
            total++; if (c_q !== expq[n] || c_qn !== ~expq[n]) begin bad++; $display("FAIL w1_step%0d got q=%b qn=%b exp q=%b", n, c_q, c_qn, expq[n]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            a_en = ($urandom_range(0, 3) != 0); a_mode = 2'($urandom_range(0, 3));
            a_j = 4'($urandom); a_k = 4'($urandom); a_up = 1'($urandom);
            b_en = ($urandom_range(0, 3) != 0); b_mode = 2'($urandom_range(0, 3));
            b_j = 4'($urandom); b_k = 4'($urandom); b_up = 1'($urandom);
            c_en = 1'($urandom); c_mode = 2'($urandom_range(0, 3));
            c_j = 1'($urandom); c_k = 1'($urandom); c_up = 1'($urandom);
            tick();
            total++; if (a_q !== ma_q[3:0] || a_qn !== ~(ma_q[3:0]) || a_changed !== ma_changed) begin bad++; $display("FAIL rnd_a%0d got q=%h qn=%h ch=%b exp q=%h ch=%b", n, a_q, a_qn, a_changed, ma_q[3:0], ma_changed); end
            total++; if (a_tc !== model_tc(ma_q, 4, 0, a_mode, a_up)) begin bad++; $display("FAIL rnd_a_tc%0d got=%b", n, a_tc); end
            total++; if (b_q !== mb_q[3:0] || b_changed !== mb_changed || b_tc !== model_tc(mb_q, 4, 10, b_mode, b_up)) begin bad++; $display("FAIL rnd_b%0d got q=%h ch=%b tc=%b exp q=%h ch=%b", n, b_q, b_changed, b_tc, mb_q[3:0], mb_changed); end
            total++; if (c_q !== mc_q[0:0] || c_changed !== mc_changed || c_tc !== model_tc(mc_q, 1, 0, c_mode, c_up)) begin bad++; $display("FAIL rnd_c%0d got q=%b ch=%b tc=%b exp q=%b ch=%b", n, c_q, c_changed, c_tc, mc_q[0:0], mc_changed); end
        end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_load_toggle();
        test_count_free();
        test_count_mod();
        test_async_reset();
        test_width1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
